// File: rtl/adder_gear_corr_seq.sv
// GeAr approximate adder (sub-adder length R+P, stride R) with an optional
// multi-cycle pass that repairs one mispredicted window per cycle.
module adder_gear_corr_seq #(
   parameter int DW    = 32,
   parameter int R     = 8,
   parameter int P     = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [DW-1:0]    i_a,
   input  logic [DW-1:0]    i_b,
   input  logic             i_exact,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [DW-1:0]    o_sum,
   output logic             o_err,
   output logic [CNT_W-1:0] o_err_cnt,
   input  logic             i_clr_cnt
);
   localparam int L     = R + P;
   localparam int K     = 1 + (DW - L) / R;
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_CORR, ST_HOLD} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [DW-1:0]    a_q, a_d;
   logic [DW-1:0]    b_q, b_d;
   logic [DW-1:0]    fix_q, fix_d;
   logic             err_q, err_d;
   logic             cy_q, cy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             inc;

   logic [DW-1:0]     approx;
   logic [L:0]        win0_sum;
   logic              cy_cur;
   logic [K-1:1]      c_ov;
   logic [K-1:1][R:0] hi_sum;

   // The first correction cycle takes its incoming carry straight from window 0.
   assign win0_sum       = {1'b0, a_q[L-1:0]} + {1'b0, b_q[L-1:0]};
   assign approx[L-1:0]  = win0_sum[L-1:0];
   assign cy_cur         = (idx_q == IDX_W'(1)) ? win0_sum[L] : cy_q;

   genvar gi;
   generate
      for (gi = 1; gi < K; gi++) begin : g_win
         localparam int LO = gi * R;
         assign c_ov[gi]           = 1'(({1'b0, a_q[LO +: P]} + {1'b0, b_q[LO +: P]}) >> P);
         assign approx[LO+P +: R]  = a_q[LO+P +: R] + b_q[LO+P +: R] + R'(c_ov[gi]);
         assign hi_sum[gi]         = {1'b0, a_q[LO+P +: R]} + {1'b0, b_q[LO+P +: R]}
                                     + (R+1)'(cy_cur);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      fix_d   = fix_q;
      err_d   = err_q;
      cy_d    = cy_q;
      inc     = 1'b0;
      o_ready = 1'b0;
      case (state_q)
         ST_IDLE: o_ready = 1'b1;
         ST_CORR: begin
            // fix holds approx^exact per repaired window, so o_sum = approx ^ fix.
            for (int w = 1; w < K; w++) begin
               if (idx_q == IDX_W'(w)) begin
                  cy_d = hi_sum[w][R];
                  if (cy_cur != c_ov[w]) begin
                     fix_d[w*R+P +: R] = hi_sum[w][R-1:0] ^ approx[w*R+P +: R];
                     err_d             = 1'b1;
                     inc               = 1'b1;
                  end
               end
            end
            if (idx_q == IDX_W'(K-1)) state_d = ST_HOLD;
            else                      idx_d   = idx_q + IDX_W'(1);
         end
         ST_HOLD: begin
            o_ready = i_ready;
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      accept = i_valid && o_ready;
      if (accept) begin
         a_d   = i_a;
         b_d   = i_b;
         fix_d = '0;
         err_d = 1'b0;
         cy_d  = 1'b0;
         if (!i_exact || K == 1) begin
            state_d = ST_HOLD;
            idx_d   = '0;
         end else begin
            state_d = ST_CORR;
            idx_d   = IDX_W'(1);
         end
      end

      cnt_d = cnt_q;
      if (i_clr_cnt)                cnt_d = '0;
      else if (inc && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         fix_q   <= '0;
         err_q   <= 1'b0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fix_q   <= fix_d;
         err_q   <= err_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_valid   = (state_q == ST_HOLD);
   assign o_sum     = approx ^ fix_q;
   assign o_err     = err_q;
   assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_adder_gear_corr_seq.sv
// Bench for adder_gear_corr_seq: directed and random operations against a
// window-level reference model; a CNT_W=2 twin shares the inputs to exercise saturation.
module tb_adder_gear_corr_seq;
   localparam int DW = 32;
   localparam int R  = 8;
   localparam int P  = 8;
   localparam int L  = R + P;
   localparam int K  = 1 + (DW - L) / R;

   logic          clk = 1'b0;
   logic          i_rstn = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ready = 1'b1;
   logic [DW-1:0] i_a = '0;
   logic [DW-1:0] i_b = '0;
   logic          i_exact = 1'b0;
   logic          i_clr_cnt = 1'b0;

   logic          o_ready, o_valid, o_err;
   logic [DW-1:0] o_sum;
   logic [15:0]   o_err_cnt;
   logic          s_ready, s_valid, s_err;
   logic [DW-1:0] s_sum;
   logic [1:0]    s_cnt;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [15:0]   exp_cnt  = '0;
   logic [1:0]    exp_cnt_s = '0;

   always #5 clk = ~clk;

   adder_gear_corr_seq #(.DW(DW), .R(R), .P(P), .CNT_W(16)) dut (
      .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_exact(i_exact), .o_valid(o_valid), .i_ready(i_ready),
      .o_sum(o_sum), .o_err(o_err), .o_err_cnt(o_err_cnt), .i_clr_cnt(i_clr_cnt));

   adder_gear_corr_seq #(.DW(DW), .R(R), .P(P), .CNT_W(2)) dut_s (
      .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(s_ready),
      .i_a(i_a), .i_b(i_b), .i_exact(i_exact), .o_valid(s_valid), .i_ready(i_ready),
      .o_sum(s_sum), .o_err(s_err), .o_err_cnt(s_cnt), .i_clr_cnt(i_clr_cnt));

   // Reference: each window is an independent (R+P)-bit add; keep its top R bits.
   function automatic logic [DW-1:0] model_approx(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint unsigned la, lb, res, ws, lo, mask_l;
      la = a; lb = b; res = 0;
      mask_l = (64'd1 << L) - 1;
      for (int w = 0; w < K; w++) begin
         lo = w * R;
         ws = ((la >> lo) & mask_l) + ((lb >> lo) & mask_l);
         if (w == 0) res = res | (ws & mask_l);
         else        res = res | (((ws >> P) & ((64'd1 << R) - 1)) << (lo + P));
      end
      return res[DW-1:0];
   endfunction

   // Windows whose P-bit overlap carry disagrees with the true carry of the full add.
   function automatic int model_nerr(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint unsigned la, lb, lo, m, t, cov, mp;
      int n;
      la = a; lb = b; n = 0;
      mp = (64'd1 << P) - 1;
      for (int w = 1; w < K; w++) begin
         lo  = w * R;
         m   = (64'd1 << (lo + P)) - 1;
         t   = ((la & m) + (lb & m)) >> (lo + P);
         cov = (((la >> lo) & mp) + ((lb >> lo) & mp)) >> P;
         if (t != cov) n++;
      end
      return n;
   endfunction

   task automatic model_count(input int n);
      int s, ss;
      s  = int'(exp_cnt) + n;
      ss = int'(exp_cnt_s) + n;
      exp_cnt   = (s > 65535) ? 16'hFFFF : 16'(s);
      exp_cnt_s = (ss > 3) ? 2'd3 : 2'(ss);
   endtask

   task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ex,
                        output logic [DW-1:0] sum, output logic err, output int lat,
                        output logic to);
      int g;
      to = 1'b0;
      @(negedge clk);
      i_a = a; i_b = b; i_exact = ex; i_valid = 1'b1; i_ready = 1'b1;
      #1;
      g = 0;
      while (!o_ready && g < 20) begin @(negedge clk); g++; end
      @(posedge clk); #1;
      i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_exact = 1'($urandom);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!o_valid && lat < 20);
      to  = !o_valid || (g >= 20);
      sum = o_sum;
      err = o_err;
      $display("op a=%08h b=%08h exact=%0d sum=%08h err=%0d lat=%0d cnt=%0d cnt2=%0d",
               a, b, ex, sum, err, lat, o_err_cnt, s_cnt);
   endtask

   task automatic test_reset;
      i_rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({o_valid, o_ready, o_sum, o_err, o_err_cnt} !== {1'b0, 1'b1, 32'h0, 1'b0, 16'h0}) begin
         n_fail++;
         $display("FAIL reset_state: valid=%0d ready=%0d sum=%08h err=%0d cnt=%0d, required 0 1 0 0 0",
                  o_valid, o_ready, o_sum, o_err, o_err_cnt);
      end
      i_rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%0d valid=%0d, required 1 0", o_ready, o_valid);
      end
      exp_cnt = '0; exp_cnt_s = '0;
   endtask

   task automatic test_directed;
      logic [DW-1:0] ta [6] = '{32'h0000FFFF, 32'h0000FFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h12345678, 32'hFFFFFFFF};
      logic [DW-1:0] tb [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h11111111, 32'h1};
      logic          tx [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [DW-1:0] ts [6] = '{32'h00010000, 32'h0, 32'h01000000, 32'h00FF0000, 32'h23456789, 32'h0};
      logic          te [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int            tl [6] = '{3, 1, 3, 1, 3, 3};
      logic [15:0]   tc [6] = '{16'd1, 16'd1, 16'd3, 16'd3, 16'd3, 16'd5};
      logic [1:0]    tcs[6] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
      logic [DW-1:0] sum;
      logic          err, to;
      int            lat;
      for (int i = 0; i < 6; i++) begin
         do_op(ta[i], tb[i], tx[i], sum, err, lat, to);
         n_checks++;
         if (to || sum !== ts[i] || err !== te[i] || lat != tl[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: sum=%08h err=%0d lat=%0d timeout=%0d, required sum=%08h err=%0d lat=%0d",
                     i, sum, err, lat, to, ts[i], te[i], tl[i]);
         end
         n_checks++;
         if (o_err_cnt !== tc[i] || s_cnt !== tcs[i]) begin
            n_fail++;
            $display("FAIL directed_cnt_%0d: cnt=%0d cnt2=%0d, required %0d %0d",
                     i, o_err_cnt, s_cnt, tc[i], tcs[i]);
         end
      end
      exp_cnt = 16'd5; exp_cnt_s = 2'd3;
   endtask

   task automatic test_random;
      logic [DW-1:0] a, b, sum, esum;
      logic          ex, err, eerr, to;
      int            lat, n;
      for (int i = 0; i < 30; i++) begin
         a = $urandom; b = $urandom; ex = 1'($urandom);
         case ($urandom_range(0, 2))
            0: begin a = a | 32'h00FFFF00; b = {24'h0, b[7:0]}; end
            1: b = ~a ^ (32'h1 << $urandom_range(0, 31));
            default: ;
         endcase
         n    = model_nerr(a, b);
         esum = ex ? a + b : model_approx(a, b);
         eerr = ex && (n > 0);
         if (ex) model_count(n);
         do_op(a, b, ex, sum, err, lat, to);
         n_checks++;
         if (to || sum !== esum || err !== eerr || lat != (ex ? K : 1)) begin
            n_fail++;
            $display("FAIL random_%0d: a=%08h b=%08h ex=%0d sum=%08h err=%0d lat=%0d, required sum=%08h err=%0d lat=%0d",
                     i, a, b, ex, sum, err, lat, esum, eerr, ex ? K : 1);
         end
         n_checks++;
         if (o_err_cnt !== exp_cnt || s_cnt !== exp_cnt_s) begin
            n_fail++;
            $display("FAIL random_cnt_%0d: cnt=%0d cnt2=%0d, required %0d %0d",
                     i, o_err_cnt, s_cnt, exp_cnt, exp_cnt_s);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [DW-1:0] a1, b1, a2, b2, esum1;
      logic          eerr1;
      int            g;
      a1 = 32'h00FFFFFF; b1 = {24'h0, 8'($urandom_range(1, 255))};
      a2 = $urandom; b2 = $urandom;
      esum1 = a1 + b1;
      eerr1 = model_nerr(a1, b1) > 0;
      model_count(model_nerr(a1, b1));
      @(negedge clk);
      i_a = a1; i_b = b1; i_exact = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
      @(posedge clk); #1;
      i_a = a2; i_b = b2; i_exact = 1'b0;
      g = 0;
      do begin @(negedge clk); g++; end while (!o_valid && g < 20);
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (o_valid !== 1'b1 || o_sum !== esum1 || o_err !== eerr1 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold_%0d: valid=%0d sum=%08h err=%0d ready=%0d, required 1 %08h %0d 0",
                     c, o_valid, o_sum, o_err, o_ready, esum1, eerr1);
         end
         if (c < 4) @(negedge clk);
      end
      $display("op a=%08h b=%08h exact=1 sum=%08h held 5 cycles", a1, b1, o_sum);
      i_ready = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_ready: ready=%0d, required 1", o_ready);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1 || o_sum !== model_approx(a2, b2) || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_next: valid=%0d sum=%08h err=%0d, required 1 %08h 0",
                  o_valid, o_sum, o_err, model_approx(a2, b2));
      end
      $display("op a=%08h b=%08h exact=0 sum=%08h accepted from hold", a2, b2, o_sum);
   endtask

   task automatic test_back_to_back(input logic ex);
      logic [DW-1:0] q_sum[$];
      logic          q_err[$];
      logic [DW-1:0] ca, cb;
      int            accepted, done, last_valid, n;
      logic          go;
      accepted = 0; done = 0; last_valid = -1;
      @(negedge clk);
      ca = $urandom; cb = $urandom;
      i_a = ca; i_b = cb; i_exact = ex; i_valid = 1'b1; i_ready = 1'b1;
      #1;
      for (int cyc = 0; cyc < 200 && done < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (o_valid) begin
            n_checks++;
            if (q_sum.size() == 0 || o_sum !== q_sum[0] || o_err !== q_err[0]) begin
               n_fail++;
               $display("FAIL b2b_result_%0d: sum=%08h err=%0d, required %08h %0d",
                        done, o_sum, o_err, (q_sum.size() > 0) ? q_sum[0] : 32'hX,
                        (q_err.size() > 0) ? q_err[0] : 1'bX);
            end
            $display("b2b exact=%0d result %0d sum=%08h err=%0d cycle=%0d", ex, done, o_sum, o_err, cyc);
            if (last_valid >= 0) begin
               n_checks++;
               if (cyc - last_valid != (ex ? K : 1)) begin
                  n_fail++;
                  $display("FAIL b2b_gap_%0d: gap=%0d, required %0d", done, cyc - last_valid, ex ? K : 1);
               end
            end
            last_valid = cyc;
            if (q_sum.size() > 0) begin void'(q_sum.pop_front()); void'(q_err.pop_front()); end
            done++;
         end
         go = o_ready && i_valid;
         if (go) begin
            n = model_nerr(ca, cb);
            q_sum.push_back(ex ? ca + cb : model_approx(ca, cb));
            q_err.push_back(ex && n > 0);
            if (ex) model_count(n);
            accepted++;
         end
         @(posedge clk); #1;
         if (go) begin
            if (accepted == 8) i_valid = 1'b0;
            else begin ca = $urandom; cb = $urandom; i_a = ca; i_b = cb; end
         end
      end
      i_valid = 1'b0;
      n_checks++;
      if (done != 8) begin
         n_fail++;
         $display("FAIL b2b_count: results=%0d, required 8", done);
      end
      n_checks++;
      if (o_err_cnt !== exp_cnt || s_cnt !== exp_cnt_s) begin
         n_fail++;
         $display("FAIL b2b_cnt: cnt=%0d cnt2=%0d, required %0d %0d", o_err_cnt, s_cnt, exp_cnt, exp_cnt_s);
      end
   endtask

   task automatic test_clear_same_cycle;
      int g;
      @(negedge clk);
      i_a = 32'h00FFFFFF; i_b = 32'h1; i_exact = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_accept_ready: ready=%0d, required 1", o_ready);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      i_clr_cnt = 1'b1;
      @(posedge clk); #1;
      i_clr_cnt = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_err_cnt !== 16'd0 || s_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL clear_wins: cnt=%0d cnt2=%0d, required 0 0", o_err_cnt, s_cnt);
      end
      g = 0;
      while (!o_valid && g < 20) begin @(negedge clk); g++; end
      n_checks++;
      if (!o_valid || o_sum !== 32'h01000000 || o_err_cnt !== 16'd1 || s_cnt !== 2'd1) begin
         n_fail++;
         $display("FAIL clear_after: valid=%0d sum=%08h cnt=%0d cnt2=%0d, required 1 01000000 1 1",
                  o_valid, o_sum, o_err_cnt, s_cnt);
      end
      $display("op a=00ffffff b=00000001 exact=1 sum=%08h cnt=%0d with clear on first correction",
               o_sum, o_err_cnt);
      exp_cnt = 16'd1; exp_cnt_s = 2'd1;
   endtask

   task automatic test_reset_mid_corr;
      logic [DW-1:0] sum;
      logic          err, to;
      int            lat;
      @(negedge clk);
      i_a = 32'hFFFFFFFF; i_b = 32'h1; i_exact = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(negedge clk);
      i_rstn = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_ready, o_sum, o_err, o_err_cnt, s_cnt} !== {1'b0, 1'b1, 32'h0, 1'b0, 16'h0, 2'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_corr: valid=%0d ready=%0d sum=%08h err=%0d cnt=%0d cnt2=%0d, required 0 1 0 0 0 0",
                  o_valid, o_ready, o_sum, o_err, o_err_cnt, s_cnt);
      end
      @(negedge clk);
      i_rstn = 1'b1;
      exp_cnt = '0; exp_cnt_s = '0;
      do_op(32'h0000FFFF, 32'h1, 1'b1, sum, err, lat, to);
      n_checks++;
      if (to || sum !== 32'h00010000 || err !== 1'b1 || o_err_cnt !== 16'd1 || lat != K) begin
         n_fail++;
         $display("FAIL after_reset_op: sum=%08h err=%0d cnt=%0d lat=%0d, required 00010000 1 1 %0d",
                  sum, err, o_err_cnt, lat, K);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_backpressure;
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_clear_same_cycle;
      test_reset_mid_corr;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
